// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the multi-cycle bitwise logic unit: operation codes and FSM states.
package bitwise_logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : bitwise_logic_pkg

// File: rtl/logic_slice.sv
// Combinational bitwise operator for one SLICE-bit slice of the operands.
module logic_slice
    import bitwise_logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] r_s
);

    // Select the requested bitwise function for this slice.
    always_comb begin
        // NOTE: assign a default before the case so every path drives r_s and no latch is inferred.
        r_s = '0;
        case (op)
            OP_AND:  r_s = a_s & b_s;
            OP_OR:   r_s = a_s | b_s;
            OP_XOR:  r_s = a_s ^ b_s;
            OP_NOR:  r_s = ~(a_s | b_s);
            default: r_s = '0;
        endcase
    end

endmodule : logic_slice

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per cycle, valid/ready on both sides.
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    // A partial top slice would silently drop operand bits, so refuse to build.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("bitwise_logic_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] r_s;
    logic             accept;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign res       = res_q;
    assign zero      = (res_q == '0);

    // State register; reset drops any in-flight request on the spot.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, walk the slices in BUSY, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Route the slice currently being worked on into the shared operator.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_s = a_q[i*SLICE +: SLICE];
                b_s = b_q[i*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .r_s (r_s)
    );

    // Operand latches, slice counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_AND;
            cnt_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            // Every slice is written once per request, so no stale bits survive.
            for (int i = 0; i < NSLICE; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    res_q[i*SLICE +: SLICE] <= r_s;
                end
            end
            // Park on the last slice instead of wrapping.
            if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule : bitwise_logic_unit

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench: three unit configurations against a transaction-level model plus directed literals.
module tb_bitwise_logic_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: WIDTH=32 SLICE=8, index 1: WIDTH=32 SLICE=32, index 2: WIDTH=16 SLICE=4.
    logic [31:0] a_d [3];
    logic [31:0] b_d [3];
    logic [1:0]  op_d [3];
    logic        iv_d [3];
    logic        ordy_d [3];

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        z0, z1, z2;
    logic [31:0] r0, r1;
    logic [15:0] r2;

    logic        ir_d [3];
    logic        ov_d [3];
    logic        z_d [3];
    logic [31:0] r_d [3];

    int checks = 0;
    int errors = 0;

    always_comb begin
        ir_d[0] = ir0; ir_d[1] = ir1; ir_d[2] = ir2;
        ov_d[0] = ov0; ov_d[1] = ov1; ov_d[2] = ov2;
        z_d[0]  = z0;  z_d[1]  = z1;  z_d[2]  = z2;
        r_d[0]  = r0;  r_d[1]  = r1;  r_d[2]  = {16'h0000, r2};
    end

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv_d[0]), .in_ready(ir0),
        .a(a_d[0]), .b(b_d[0]), .op(op_d[0]),
        .out_valid(ov0), .out_ready(ordy_d[0]), .res(r0), .zero(z0)
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv_d[1]), .in_ready(ir1),
        .a(a_d[1]), .b(b_d[1]), .op(op_d[1]),
        .out_valid(ov1), .out_ready(ordy_d[1]), .res(r1), .zero(z1)
    );

    bitwise_logic_unit #(.WIDTH(16), .SLICE(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv_d[2]), .in_ready(ir2),
        .a(a_d[2][15:0]), .b(b_d[2][15:0]), .op(op_d[2]),
        .out_valid(ov2), .out_ready(ordy_d[2]), .res(r2), .zero(z2)
    );

    function automatic int nslice(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] wmask(input int k);
        return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    // Whole-word reference function.
    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycles left until the result appears, and whether one is presented.
    int          m_left [3];
    bit          m_done [3];
    logic [31:0] m_res [3];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_left[k] <= 0;
                m_done[k] <= 1'b0;
                m_res[k]  <= 32'h0;
            end else if (m_done[k]) begin
                if (ordy_d[k]) m_done[k] <= 1'b0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) m_done[k] <= 1'b1;
            end else if (iv_d[k]) begin
                m_left[k] <= nslice(k);
                m_res[k]  <= ref_op(op_d[k], a_d[k], b_d[k]) & wmask(k);
            end
        end
    end

    // Compare every unit against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("in_ready[%0d]", k), {31'b0, ir_d[k]}, {31'b0, (!m_done[k] && m_left[k] == 0)});
            check($sformatf("out_valid[%0d]", k), {31'b0, ov_d[k]}, {31'b0, m_done[k]});
            if (m_done[k]) begin
                check($sformatf("res[%0d]", k), r_d[k], m_res[k]);
                check($sformatf("zero[%0d]", k), {31'b0, z_d[k]}, {31'b0, (m_res[k] == 32'h0)});
            end
            if (rst) begin
                check($sformatf("rst_res[%0d]", k), r_d[k], 32'h0);
                check($sformatf("rst_zero[%0d]", k), {31'b0, z_d[k]}, 32'h1);
            end
        end
    end

    // Issue one request, measure latency, optionally apply backpressure with ignored traffic, then drain.
    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic [31:0] exp, input logic exp_zero, input int exp_lat,
                           input int hold, input string name);
        int lat;
        int wait_n;
        wait_n = 0;
        while (!ir_d[k] && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check({name, "_ready"}, {31'b0, ir_d[k]}, 32'h1);
        a_d[k] = a; b_d[k] = b; op_d[k] = op; iv_d[k] = 1'b1;
        @(posedge clk); #1;
        iv_d[k] = 1'b0;
        lat = 0;
        while (!ov_d[k] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_res"}, r_d[k], exp);
        check({name, "_zero"}, {31'b0, z_d[k]}, {31'b0, exp_zero});
        for (int i = 0; i < hold; i++) begin
            iv_d[k] = i[0];
            a_d[k]  = $urandom;
            b_d[k]  = $urandom;
            op_d[k] = 2'(i);
            @(posedge clk); #1;
            check({name, "_hold_res"}, r_d[k], exp);
            check({name, "_hold_in_ready"}, {31'b0, ir_d[k]}, 32'h0);
            check({name, "_hold_out_valid"}, {31'b0, ov_d[k]}, 32'h1);
        end
        iv_d[k] = 1'b0;
        ordy_d[k] = 1'b1;
        @(posedge clk); #1;
        ordy_d[k] = 1'b0;
        check({name, "_drain_out_valid"}, {31'b0, ov_d[k]}, 32'h0);
        check({name, "_drain_in_ready"}, {31'b0, ir_d[k]}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rexp;
        logic [1:0]  rop;
        int          k;
        for (int i = 0; i < 3; i++) begin
            a_d[i] = '0; b_d[i] = '0; op_d[i] = '0; iv_d[i] = 1'b0; ordy_d[i] = 1'b0;
        end

        // Reset values with no stimulus.
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, ir0}, 32'h1);
        check("reset_out_valid", {31'b0, ov0}, 32'h0);
        check("reset_res", r0, 32'h0);
        check("reset_zero", {31'b0, z0}, 32'h1);
        rst = 1'b0;

        // Directed vectors on the 32/8 unit.
        run_txn(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 32'hF000_F000, 1'b0, 4, 0, "and");
        run_txn(0, 32'h1234_5678, 32'h1234_5678, 2'b10, 32'h0000_0000, 1'b1, 4, 0, "xor");
        run_txn(0, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1'b0, 4, 0, "nor");
        run_txn(0, 32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 32'hFFFF_FFFF, 1'b0, 4, 0, "or");

        // Backpressure with new requests offered while the result is held.
        run_txn(0, 32'hA5A5_0F0F, 32'h0FF0_3C3C, 2'b10, 32'hAA55_3333, 1'b0, 4, 6, "bp");

        // Reset in the middle of an AND request.
        a_d[0] = 32'hF0F0_F0F0; b_d[0] = 32'hFF00_FF00; op_d[0] = 2'b00; iv_d[0] = 1'b1;
        @(posedge clk); #1;
        iv_d[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, ov0}, 32'h0);
        check("midrst_res", r0, 32'h0);
        check("midrst_in_ready", {31'b0, ir0}, 32'h1);
        check("midrst_zero", {31'b0, z0}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", {31'b0, ov0}, 32'h0);
        end
        run_txn(0, 32'hAAAA_AAAA, 32'h5555_5555, 2'b01, 32'hFFFF_FFFF, 1'b0, 4, 0, "after_rst");

        // Other configurations: single-slice and 16/4.
        run_txn(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 32'hF000_F000, 1'b0, 1, 0, "s32_and");
        run_txn(2, 32'h0000_00FF, 32'h0000_0F0F, 2'b11, 32'h0000_F000, 1'b0, 4, 0, "w16_nor");

        // Random operations across all three units.
        for (int n = 0; n < 200; n++) begin
            k    = n % 3;
            ra   = $urandom;
            rb   = (n % 5 == 0) ? ra : $urandom;
            rop  = 2'($urandom_range(3, 0));
            rexp = ref_op(rop, ra, rb) & wmask(k);
            run_txn(k, ra, rb, rop, rexp, (rexp == 32'h0), nslice(k), $urandom_range(2, 0), "rand");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bitwise_logic_unit

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, multi-cycle bitwise logic unit for the MIPS datapath. It computes AND, OR, XOR or NOR of two WIDTH-bit operands. The work is done one SLICE-bit slice per cycle, which trades latency for gate count. A valid/ready handshake sits on each side, so the block can stand in for single-function combinational gate arrays in the ALU logic path.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE, otherwise an elaboration error.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res  output  WIDTH  result.
- zero  output  1  res == 0; valid while out_valid is high.

## Operation
- FSM states:
  - IDLE: in_ready=1.
    - Accept on in_valid && in_ready.
    - On accept, latch a, b and op; clear cnt to 0; go to BUSY.
  - BUSY: in_ready=0.
    - Each cycle, write res[cnt*SLICE +: SLICE] = f(op, a_slice, b_slice).
    - Increment cnt.
    - When cnt == NSLICE-1 on that edge, go to DONE.
  - DONE: out_valid=1; res and zero held stable.
    - On out_ready, go to IDLE.
- Inputs a, b, op and in_valid are ignored outside IDLE, and the latched operands are unaffected.
- NOR is ~(a|b) per bit, applied to every slice including the top one.
- cnt width is clog2(NSLICE), minimum 1 bit; it never wraps past NSLICE-1.
- res is fully overwritten for every request. No bits from a previous result survive.
- zero is computed combinationally from the res register.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, res=0, zero=1, cnt=0, latched operands=0.
- Accept at edge E0. BUSY runs for edges E1..E_NSLICE. out_valid is high after edge E_NSLICE, giving latency NSLICE cycles from accept to out_valid.
- NSLICE=1 (SLICE=WIDTH): out_valid is high 1 cycle after accept.
- Result handshake at edge Ek (out_valid && out_ready): out_valid falls and in_ready rises after Ek. The next accept can happen at E(k+1) at the earliest, so the minimum spacing between requests is NSLICE+2 cycles.
- Backpressure: out_ready may stay low indefinitely. out_valid, res and zero hold unchanged.
- in_valid asserted while BUSY or DONE: no effect, not queued.
- rst asserted mid-BUSY or in DONE: all state and outputs immediately return to reset values. The in-flight result is discarded and never presented.
- rst deasserts synchronously to clk. The first accept is possible on the first edge after deassertion.

## Structure
- Package bitwise_logic_pkg:
  - op encoding constants OP_AND, OP_OR, OP_XOR, OP_NOR.
  - state typedef {IDLE, BUSY, DONE}.
- Sub-module logic_slice #(SLICE): purely combinational; inputs op, a_s, b_s; output r_s. Instantiated once and fed by a cnt-indexed mux.
- Top level contains the FSM, cnt, operand/op latches and the res register.

## Test plan
- Reset, no stimulus: in_ready=1, out_valid=0, res=0, zero=1. Assert rst mid-run: same values on the next sample.
- AND, WIDTH=32, SLICE=8:
  - Stimulus: a=0xF0F0F0F0, b=0xFF00FF00.
  - Response: out_valid exactly 4 cycles after accept, res=0xF000F000, zero=0.
- XOR, then NOR:
  - XOR with a=b=0x12345678: res=0, zero=1.
  - NOR with a=b=0: res=0xFFFFFFFF.
  - OR with a=0x0000FFFF, b=0xFFFF0000: res=0xFFFFFFFF.
- Backpressure:
  - Hold out_ready=0 for 6 cycles after out_valid: res stable, in_ready=0.
  - Toggle in_valid with new operands during that window: those operands are not accepted and the result is unchanged.
- Reset mid-BUSY:
  - Assert rst at cycle 2 of an AND request: out_valid never rises, res=0.
  - Next request a=0xAAAAAAAA OR b=0x55555555: res=0xFFFFFFFF.
- Parameter sweep: SLICE=32, WIDTH=32 gives 1-cycle latency. WIDTH=16, SLICE=4 gives 4-cycle latency. Check 200 random op/operand pairs against a reference model.
